execution_tb_ace_sky_burst_addr_gen: RTL and testbench

//  Sequential per-beat address generator for ACE/Skyros testbench masters and slaves.

---
 rtl/execution_tb_ace_sky_pkg.sv | 27 ++
 rtl/execution_tb_ace_sky_addr_step.sv | 35 +++
 rtl/execution_tb_ace_sky_burst_addr_gen.sv | 132 +++++++++++++
 tb/tb_execution_tb_ace_sky_burst_addr_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execution_tb_ace_sky_pkg.sv
//------------------------------------------------------------------------------
// execution_tb_ace_sky_pkg : shared burst encodings, FSM states, error indices
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package execution_tb_ace_sky_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int ERR_WRAP  = 0;
    localparam int ERR_SIZE  = 1;
    localparam int ERR_BURST = 2;

    localparam int PAGE_BITS = 12;

endpackage

`default_nettype wire

// File: rtl/execution_tb_ace_sky_addr_step.sv
//------------------------------------------------------------------------------
// execution_tb_ace_sky_addr_step : next in-page beat address for FIXED/INCR/WRAP
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module execution_tb_ace_sky_addr_step
    import execution_tb_ace_sky_pkg::*;
(
    input  logic [PAGE_BITS-1:0] addr,
    input  logic [3:0]           len,
    input  logic [2:0]           size,
    input  logic [1:0]           burst,
    output logic [PAGE_BITS-1:0] next_addr
);

    logic [PAGE_BITS-1:0] beat_num;
    logic [PAGE_BITS-1:0] beat_inc;
    logic [PAGE_BITS-1:0] beat_wrap;

    always_comb begin
        beat_num  = addr >> size;
        beat_inc  = beat_num + PAGE_BITS'(1);
        // Only the low beat-number bits selected by len advance; the rest stay put.
        beat_wrap = {beat_num[PAGE_BITS-1:4], (len & beat_inc[3:0]) | (~len & beat_num[3:0])};
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = beat_wrap << size;
            default:     next_addr = beat_inc << size;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/execution_tb_ace_sky_burst_addr_gen.sv
//------------------------------------------------------------------------------
// execution_tb_ace_sky_burst_addr_gen : one burst command in, one address per beat out
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module execution_tb_ace_sky_burst_addr_gen
    import execution_tb_ace_sky_pkg::*;
#(
    parameter int ADDR_W   = 44,
    parameter int LEN_W    = 8,
    parameter int MAX_SIZE = 4,
    parameter int ID_W     = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [2:0]        cmd_size_i,
    input  logic [1:0]        cmd_burst_i,
    input  logic [ID_W-1:0]   cmd_id_i,
    output logic              beat_valid_o,
    input  logic              beat_ready_i,
    output logic [ADDR_W-1:0] beat_addr_o,
    output logic [ID_W-1:0]   beat_id_o,
    output logic [LEN_W-1:0]  beat_idx_o,
    output logic              beat_first_o,
    output logic              beat_last_o,
    output logic              busy_o,
    output logic [2:0]        cmd_err_o
);

    localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);

    state_t               state;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic [3:0]           wrap_len_q;
    logic [LEN_W-1:0]     remain_q;
    logic [PAGE_BITS-1:0] step_addr;

    logic                 cmd_fire;
    logic                 beat_fire;
    logic                 size_err;
    logic                 rsvd_err;
    logic                 wrap_err;
    logic                 len_ok;
    logic [2:0]           size_clamped;
    logic [1:0]           burst_eff;
    logic [PAGE_BITS-1:0] align_mask;

    assign beat_valid_o = (state == ACTIVE);
    assign busy_o       = beat_valid_o;
    assign cmd_ready_o  = !beat_valid_o || (beat_ready_i && beat_last_o);
    assign cmd_fire     = cmd_valid_i && cmd_ready_o;
    assign beat_fire    = beat_valid_o && beat_ready_i;

    always_comb begin
        size_err     = (cmd_size_i > MAX_SIZE_L);
        size_clamped = size_err ? MAX_SIZE_L : cmd_size_i;
        align_mask   = (PAGE_BITS'(1) << size_clamped) - PAGE_BITS'(1);
        rsvd_err     = (cmd_burst_i == BURST_RSVD);
        len_ok       = (cmd_len_i == LEN_W'(1)) || (cmd_len_i == LEN_W'(3)) ||
                       (cmd_len_i == LEN_W'(7)) || (cmd_len_i == LEN_W'(15));
        wrap_err     = (cmd_burst_i == BURST_WRAP) &&
                       (!len_ok || ((cmd_addr_i[PAGE_BITS-1:0] & align_mask) != '0));
        // Malformed WRAP and reserved encodings both degrade to INCR stepping.
        if (cmd_burst_i == BURST_FIXED)
            burst_eff = BURST_FIXED;
        else if (cmd_burst_i == BURST_WRAP && !wrap_err)
            burst_eff = BURST_WRAP;
        else
            burst_eff = BURST_INCR;
    end

    execution_tb_ace_sky_addr_step u_step (
        .addr      (beat_addr_o[PAGE_BITS-1:0]),
        .len       (wrap_len_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (step_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            beat_addr_o  <= '0;
            beat_id_o    <= '0;
            beat_idx_o   <= '0;
            beat_first_o <= 1'b0;
            beat_last_o  <= 1'b0;
            remain_q     <= '0;
            wrap_len_q   <= '0;
            size_q       <= '0;
            burst_q      <= BURST_FIXED;
            cmd_err_o    <= '0;
        end else begin
            cmd_err_o <= '0;
            // A command accepted alongside the last beat takes priority and reloads everything.
            if (cmd_fire) begin
                state                <= ACTIVE;
                beat_addr_o          <= cmd_addr_i;
                beat_id_o            <= cmd_id_i;
                beat_idx_o           <= '0;
                beat_first_o         <= 1'b1;
                beat_last_o          <= (cmd_len_i == '0);
                remain_q             <= cmd_len_i;
                wrap_len_q           <= cmd_len_i[3:0];
                size_q               <= size_clamped;
                burst_q              <= burst_eff;
                cmd_err_o[ERR_WRAP]  <= wrap_err;
                cmd_err_o[ERR_SIZE]  <= size_err;
                cmd_err_o[ERR_BURST] <= rsvd_err;
            end else if (beat_fire) begin
                if (beat_last_o) begin
                    state <= IDLE;
                end else begin
                    beat_addr_o  <= {beat_addr_o[ADDR_W-1:PAGE_BITS], step_addr};
                    beat_idx_o   <= beat_idx_o + LEN_W'(1);
                    remain_q     <= remain_q - LEN_W'(1);
                    beat_first_o <= 1'b0;
                    beat_last_o  <= (remain_q == LEN_W'(1));
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_execution_tb_ace_sky_burst_addr_gen.sv
//------------------------------------------------------------------------------
// tb_execution_tb_ace_sky_burst_addr_gen : scoreboard bench with AXI address model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_execution_tb_ace_sky_burst_addr_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [43:0] cmd_addr_i = '0;
    logic [7:0]  cmd_len_i = '0;
    logic [2:0]  cmd_size_i = '0;
    logic [1:0]  cmd_burst_i = '0;
    logic [5:0]  cmd_id_i = '0;
    logic        beat_valid_o;
    logic        beat_ready_i = 1'b0;
    logic [43:0] beat_addr_o;
    logic [5:0]  beat_id_o;
    logic [7:0]  beat_idx_o;
    logic        beat_first_o;
    logic        beat_last_o;
    logic        busy_o;
    logic [2:0]  cmd_err_o;

    always #5 clk = ~clk;

    execution_tb_ace_sky_burst_addr_gen #(
        .ADDR_W(44), .LEN_W(8), .MAX_SIZE(4), .ID_W(6)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_len_i    (cmd_len_i),
        .cmd_size_i   (cmd_size_i),
        .cmd_burst_i  (cmd_burst_i),
        .cmd_id_i     (cmd_id_i),
        .beat_valid_o (beat_valid_o),
        .beat_ready_i (beat_ready_i),
        .beat_addr_o  (beat_addr_o),
        .beat_id_o    (beat_id_o),
        .beat_idx_o   (beat_idx_o),
        .beat_first_o (beat_first_o),
        .beat_last_o  (beat_last_o),
        .busy_o       (busy_o),
        .cmd_err_o    (cmd_err_o)
    );

    typedef struct {
        logic [43:0] addr;
        logic [5:0]  id;
        logic [7:0]  idx;
        logic        first;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       got;
    int          checks = 0;
    int          failures = 0;
    int          rdy_mode = 0;
    logic [2:0]  err_next = '0;
    logic [2:0]  err_now;
    logic        first_next = 1'b0;
    logic        first_now;
    logic        hold_armed = 1'b0;
    logic [63:0] hold_vec = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // AXI address rules: aligned base plus i*bytes for INCR, wrap-boundary modulo for WRAP.
    function automatic void model_cmd(input logic [43:0] a, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst,
                                      input logic [5:0] id);
        int    sz;
        int    bytes;
        int    off;
        int    wb;
        int    lower;
        int    o;
        logic  bad_wrap;
        beat_t b;
        sz       = (size > 3'd4) ? 4 : int'(size);
        bytes    = 1 << sz;
        off      = int'(a[11:0]);
        bad_wrap = (burst == 2'b10) && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (off % bytes) != 0);
        for (int i = 0; i <= int'(len); i++) begin
            if (burst == 2'b00) begin
                o = off;
            end else if (burst == 2'b10 && !bad_wrap) begin
                wb    = bytes * (int'(len) + 1);
                lower = (off / wb) * wb;
                o     = lower + ((off - lower + i * bytes) % wb);
            end else begin
                o = (i == 0) ? off : (((off / bytes) * bytes + i * bytes) % 4096);
            end
            b.addr  = {a[43:12], 12'(o)};
            b.id    = id;
            b.idx   = 8'(i);
            b.first = (i == 0);
            b.last  = (i == int'(len));
            exp_q.push_back(b);
        end
        err_next   = {burst == 2'b11, size > 3'd4, bad_wrap};
        first_next = 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            err_next   = '0;
            first_next = 1'b0;
            hold_armed = 1'b0;
        end else begin
            err_now    = err_next;
            err_next   = '0;
            first_now  = first_next;
            first_next = 1'b0;
            check("beat_valid", 64'(beat_valid_o), 64'(exp_q.size() != 0));
            check("busy", 64'(busy_o), 64'(exp_q.size() != 0));
            check("cmd_ready", 64'(cmd_ready_o),
                  64'(exp_q.size() == 0 || (exp_q.size() == 1 && beat_ready_i)));
            check("cmd_err", 64'(cmd_err_o), 64'(err_now));
            if (first_now)
                check("beat0_latency", 64'({beat_valid_o, beat_first_o}), 64'd3);
            if (hold_armed && beat_valid_o)
                check("hold", 64'({beat_addr_o, beat_id_o, beat_idx_o, beat_first_o, beat_last_o}), hold_vec);
            hold_armed = beat_valid_o && !beat_ready_i;
            hold_vec   = 64'({beat_addr_o, beat_id_o, beat_idx_o, beat_first_o, beat_last_o});
            if (beat_valid_o && beat_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none", beat_addr_o);
                end else begin
                    got = exp_q.pop_front();
                    check("beat_addr", 64'(beat_addr_o), 64'(got.addr));
                    check("beat_id", 64'(beat_id_o), 64'(got.id));
                    check("beat_idx", 64'(beat_idx_o), 64'(got.idx));
                    check("beat_first", 64'(beat_first_o), 64'(got.first));
                    check("beat_last", 64'(beat_last_o), 64'(got.last));
                end
            end
            if (cmd_valid_i && cmd_ready_o)
                model_cmd(cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i, cmd_id_i);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1)
                beat_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_cmd(input logic [43:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [5:0] id);
        int n;
        cmd_addr_i  = a;
        cmd_len_i   = len;
        cmd_size_i  = size;
        cmd_burst_i = burst;
        cmd_id_i    = id;
        cmd_valid_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready_o && n < 2000);
        if (!cmd_ready_o) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [43:0] ra;
        logic [7:0]  rl;
        logic [2:0]  rs;
        logic [1:0]  rb;

        repeat (3) @(posedge clk);
        #1;
        check("rst_beat_valid", 64'(beat_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_cmd_err", 64'(cmd_err_o), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_beat_data", 64'({beat_addr_o, beat_id_o, beat_idx_o, beat_first_o, beat_last_o}), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        beat_ready_i = 1'b1;
        send_cmd(44'h1004, 8'd3, 3'd2, 2'b01, 6'h01);
        send_cmd(44'h013, 8'd2, 3'd3, 2'b01, 6'h02);
        send_cmd(44'h030, 8'd3, 3'd4, 2'b10, 6'h03);
        send_cmd(44'h2A0, 8'd7, 3'd2, 2'b00, 6'h04);
        send_cmd(44'hABC00001FF8, 8'd1, 3'd3, 2'b01, 6'h05);
        send_cmd(44'h040, 8'd4, 3'd2, 2'b10, 6'h06);
        send_cmd(44'h100, 8'd2, 3'd6, 2'b11, 6'h07);
        drain();

        // Stall at idx 1 for three cycles, then offer a command during the last beat.
        beat_ready_i = 1'b0;
        send_cmd(44'h500, 8'd3, 3'd2, 2'b01, 6'h08);
        beat_ready_i = 1'b1;
        @(posedge clk);
        #1;
        beat_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        beat_ready_i = 1'b1;
        send_cmd(44'h800, 8'd1, 3'd2, 2'b01, 6'h09);
        drain();

        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            ra = {$urandom, $urandom};
            rl = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 40)) :
                 (($urandom_range(0, 1) == 0) ? 8'((1 << $urandom_range(0, 4)) - 1) : 8'($urandom_range(0, 15)));
            rs = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            rb = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                ra[11:0] = ra[11:0] & ~12'hF;
            send_cmd(ra, rl, rs, rb, 6'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        #1;
        beat_ready_i = 1'b1;
        drain();

        send_cmd(44'h7000, 8'd15, 3'd0, 2'b01, 6'h0A);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(beat_valid_o), 64'd0);
        check("async_rst_busy", 64'(busy_o), 64'd0);
        check("async_rst_ready", 64'(cmd_ready_o), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(beat_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
